// File: rtl/skid_slice_pkg.sv
// Shared types for the skid_slice register slice: occupancy states and a
// helper mapping a state to its beat count.
package skid_slice_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] level_of(input skid_state_e st);
        case (st)
            ONE:     level_of = 2'd1;
            FULL:    level_of = 2'd2;
            default: level_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/skid_slice.sv
// Two-entry skid buffer: full-throughput valid/ready slice with a registered
// s_ready_o. Define SKID_SLICE_STAT_EN to add the level_o / full_seen_o outputs.
module skid_slice
    import skid_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o
`ifdef SKID_SLICE_STAT_EN
    ,
    output logic [1:0]            level_o,
    output logic                  full_seen_o
`endif
);

    skid_state_e           state_q;
    skid_state_e           state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  s_ready_q;
    logic                  s_xfer;
    logic                  m_xfer;

    assign s_xfer    = s_valid_i & s_ready_q;
    assign m_xfer    = (state_q != EMPTY) & m_ready_i;
    assign s_ready_o = s_ready_q;
    assign m_valid_o = (state_q != EMPTY);
    assign m_data_o  = main_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (s_xfer) state_d = ONE;
            ONE: begin
                if (s_xfer && !m_xfer)      state_d = FULL;
                else if (!s_xfer && m_xfer) state_d = EMPTY;
            end
            FULL:    if (m_xfer) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // s_ready_o is registered from the next state so m_ready_i never reaches it combinationally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= (state_d != FULL);
            case (state_q)
                EMPTY: if (s_xfer) main_q <= s_data_i;
                ONE: begin
                    if (s_xfer && m_xfer) main_q <= s_data_i;
                    else if (s_xfer)      skid_q <= s_data_i;
                end
                FULL:    if (m_xfer) main_q <= skid_q;
                default: ;
            endcase
        end
    end

`ifdef SKID_SLICE_STAT_EN
    logic full_seen_q;

    assign level_o     = level_of(state_q);
    assign full_seen_o = full_seen_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)                  full_seen_q <= 1'b0;
        else if (state_d == FULL)   full_seen_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_skid_slice.sv
// Self-checking bench for skid_slice: directed scenarios plus a randomized run
// compared against a queue-based occupancy model.
module tb_skid_slice;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [DW-1:0] s_data_i = '0;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [DW-1:0] m_data_o;
`ifdef SKID_SLICE_STAT_EN
    logic [1:0]    level_o;
    logic          full_seen_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: a FIFO of accepted beats, capacity two, ready registered.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_last;
    logic          m_ready;
    logic          m_full_seen;

    skid_slice #(.DATA_WIDTH(DW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .s_data_i   (s_data_i),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_data_o   (m_data_o)
`ifdef SKID_SLICE_STAT_EN
        ,
        .level_o    (level_o),
        .full_seen_o(full_seen_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic drive_cycle(input logic rst, input logic v, input logic [DW-1:0] d, input logic r);
        logic sx, mx;
        rst_i     = rst;
        s_valid_i = v;
        s_data_i  = d;
        m_ready_i = r;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_last      = '0;
            m_ready     = 1'b0;
            m_full_seen = 1'b0;
        end else begin
            sx = v && m_ready;
            mx = r && (q.size() > 0);
            if (mx) void'(q.pop_front());
            if (sx) q.push_back(d);
            if (q.size() > 0) m_last = q[0];
            m_ready = (q.size() < 2);
            if (q.size() == 2) m_full_seen = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b1, $urandom, 1'b1);
            tests_run++;
            if (s_ready_o !== 1'b0 || m_valid_o !== 1'b0 || m_data_o !== '0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got rdy=%b vld=%b data=%h, want 0/0/0", i, s_ready_o, m_valid_o, m_data_o);
            end
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        tests_run++;
        if (s_ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got rdy=%b vld=%b, want 1/0", s_ready_o, m_valid_o);
        end
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b0, 1'b1, DW'(i), 1'b1);
            tests_run++;
            if (m_valid_o !== 1'b1 || m_data_o !== DW'(i) || s_ready_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream[%0d]: got vld=%b data=%h rdy=%b, want 1/%h/1", i, m_valid_o, m_data_o, s_ready_o, i);
            end
        end
        drive_cycle(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        tests_run++;
        if (m_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_drain: got vld=%b rdy=%b, want 0/1", m_valid_o, s_ready_o);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_d [6] = '{32'hA, 32'hA, 32'hA, 32'hB, 32'hC, 32'hC};
        logic          exp_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic          exp_r [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]    exp_l [6] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        logic          in_v  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [DW-1:0] in_d  [6] = '{32'hA, 32'hB, 32'hC, 32'hC, 32'hC, 32'h0};
        logic          in_r  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, in_v[i], in_d[i], in_r[i]);
            tests_run++;
            if (m_valid_o !== exp_v[i] || (exp_v[i] && m_data_o !== exp_d[i]) || s_ready_o !== exp_r[i]) begin
                tests_failed++;
                $display("FAIL backpressure[%0d]: got vld=%b data=%h rdy=%b, want %b/%h/%b",
                         i, m_valid_o, m_data_o, s_ready_o, exp_v[i], exp_d[i], exp_r[i]);
            end
`ifdef SKID_SLICE_STAT_EN
            tests_run++;
            if (level_o !== exp_l[i] || full_seen_o !== (i >= 1)) begin
                tests_failed++;
                $display("FAIL bp_stat[%0d]: got level=%0d seen=%b, want %0d/%b", i, level_o, full_seen_o, exp_l[i], (i >= 1));
            end
`endif
        end
    endtask

    task automatic test_simultaneous();
        drive_cycle(1'b0, 1'b1, 32'h5, 1'b0);
        tests_run++;
        if (m_valid_o !== 1'b1 || m_data_o !== 32'h5 || s_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_load: got vld=%b data=%h rdy=%b, want 1/5/1", m_valid_o, m_data_o, s_ready_o);
        end
        drive_cycle(1'b0, 1'b1, 32'h6, 1'b1);
        tests_run++;
        if (m_valid_o !== 1'b1 || m_data_o !== 32'h6 || s_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_xfer: got vld=%b data=%h rdy=%b, want 1/6/1", m_valid_o, m_data_o, s_ready_o);
        end
`ifdef SKID_SLICE_STAT_EN
        tests_run++;
        if (level_o !== 2'd1) begin
            tests_failed++;
            $display("FAIL simul_level: got %0d want 1", level_o);
        end
`endif
        drive_cycle(1'b0, 1'b0, '0, 1'b1);
        tests_run++;
        if (m_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_drain: got vld=%b want 0", m_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b0, 1'b1, 32'h11, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h22, 1'b0);
        tests_run++;
        if (s_ready_o !== 1'b0 || m_data_o !== 32'h11) begin
            tests_failed++;
            $display("FAIL rstmid_full: got rdy=%b data=%h, want 0/11", s_ready_o, m_data_o);
        end
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        tests_run++;
        if (m_valid_o !== 1'b0 || s_ready_o !== 1'b0 || m_data_o !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_clear: got vld=%b rdy=%b data=%h, want 0/0/0", m_valid_o, s_ready_o, m_data_o);
        end
`ifdef SKID_SLICE_STAT_EN
        tests_run++;
        if (full_seen_o !== 1'b0 || level_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL rstmid_stat: got seen=%b level=%0d, want 0/0", full_seen_o, level_o);
        end
`endif
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h33, 1'b0);
        tests_run++;
        if (m_valid_o !== 1'b1 || m_data_o !== 32'h33) begin
            tests_failed++;
            $display("FAIL rstmid_fresh: got vld=%b data=%h, want 1/33", m_valid_o, m_data_o);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b1);
        tests_run++;
        if (m_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_drain: got vld=%b want 0 (stale beat surfaced)", m_valid_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'b0, ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
            tests_run++;
            if (m_valid_o !== (q.size() > 0) || m_data_o !== m_last || s_ready_o !== m_ready) begin
                tests_failed++;
                $display("FAIL random[%0d]: got vld=%b data=%h rdy=%b, want %b/%h/%b",
                         i, m_valid_o, m_data_o, s_ready_o, (q.size() > 0), m_last, m_ready);
            end
`ifdef SKID_SLICE_STAT_EN
            tests_run++;
            if (level_o !== 2'(q.size()) || full_seen_o !== m_full_seen) begin
                tests_failed++;
                $display("FAIL random_stat[%0d]: got level=%0d seen=%b, want %0d/%b",
                         i, level_o, full_seen_o, q.size(), m_full_seen);
            end
`endif
        end
    endtask

    initial begin
        m_last      = '0;
        m_ready     = 1'b0;
        m_full_seen = 1'b0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
